// File: rtl/hilo_unit_if.sv
// rtl/hilo_unit_if.sv - multiply/divide unit to HI/LO result handshake
//
// Purpose: carries the multiply/divide unit's status and result to the
// HI/LO register block.
// Signals:
//   md_active  level, an MD op occupies EX; held until its md_done cycle
//   md_done    one-cycle pulse, md_result valid this cycle
//   md_result  {HI,LO}: mult = {hi,lo} product, div = {remainder,quotient}
// Modports: master = MD unit (drives), slave = hilo_unit (receives).
interface hilo_unit_if;
  logic        md_active;
  logic        md_done;
  logic [63:0] md_result;

  modport master (output md_active, output md_done, output md_result);
  modport slave  (input  md_active, input  md_done, input  md_result);
endinterface

// File: rtl/hilo_unit.sv
// rtl/hilo_unit.sv - architectural HI/LO registers with MD tracking and forwarding
//
// Purpose: holds the HI/LO registers, tracks an in-flight multiply/divide
// op through IDLE/BUSY/CANCEL, commits results unless the op was flushed,
// forwards a completing result straight to MFHI/MFLO and requests a stall
// while an MF read would otherwise see a stale value.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   md (slave)          md_active / md_done / md_result from the MD unit
//   flush               pipeline flush, kills the EX op
//   mthi_we, mtlo_we    MTHI / MTLO in EX, source value mt_data
//   mfhi_re, mflo_re    MFHI / MFLO in EX, result on rd_data (combinational)
//   hi_out, lo_out      architectural HI / LO
//   hilo_stall          MF read hazard stall request (combinational)
//   busy                FSM not idle (combinational)
module hilo_unit (
  input  logic              clk,
  input  logic              rst,
  hilo_unit_if.slave        md,
  input  logic              flush,
  input  logic              mthi_we,
  input  logic              mtlo_we,
  input  logic [31:0]       mt_data,
  input  logic              mfhi_re,
  input  logic              mflo_re,
  output logic [31:0]       rd_data,
  output logic [31:0]       hi_out,
  output logic [31:0]       lo_out,
  output logic              hilo_stall,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    CANCEL = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [31:0] hi_q, lo_q;

  logic        fwd_valid;   // BUSY op completing this cycle, not killed
  logic        md_commit;   // write md_result into HI/LO at this edge
  logic        mt_ok;       // MTHI/MTLO allowed to write this cycle
  logic [31:0] hi_view, lo_view;

  always_comb begin
    fwd_valid = (state == BUSY) && md.md_done && !flush;
    // A single-cycle op completes while the FSM is still IDLE; a done pulse
    // without md_active in IDLE is spurious and never commits.
    md_commit = fwd_valid ||
                ((state == IDLE) && md.md_active && md.md_done && !flush);
    mt_ok     = (state == IDLE) && !flush;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        // A single-cycle op finishes in place, so only a multi-cycle op
        // leaves IDLE.
        if (md.md_active && !md.md_done) begin
          state_next = flush ? CANCEL : BUSY;
        end
      end
      BUSY: begin
        if (md.md_done) begin
          state_next = IDLE;
        end else if (flush) begin
          state_next = CANCEL;
        end
      end
      CANCEL: begin
        // The killed op still has to drain; wait for its done pulse.
        if (md.md_done) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      hi_q  <= 32'd0;
      lo_q  <= 32'd0;
    end else begin
      state <= state_next;
      // MD results and MT writes cannot coincide in practice; the MD
      // result takes precedence if they ever do.
      if (md_commit) begin
        hi_q <= md.md_result[63:32];
        lo_q <= md.md_result[31:0];
      end else if (mt_ok) begin
        if (mthi_we) hi_q <= mt_data;
        if (mtlo_we) lo_q <= mt_data;
      end
    end
  end

  always_comb begin
    hi_view    = fwd_valid ? md.md_result[63:32] : hi_q;
    lo_view    = fwd_valid ? md.md_result[31:0]  : lo_q;
    rd_data    = mfhi_re ? hi_view : (mflo_re ? lo_view : 32'd0);
    hilo_stall = (mfhi_re || mflo_re) && (state != IDLE) && !fwd_valid;
    busy       = (state != IDLE);
    hi_out     = hi_q;
    lo_out     = lo_q;
  end

endmodule
